// File: rtl/index_decoder3to8.sv
// Rebuilds an 8-bit request vector from a serial stream of 3-bit set-bit indices
// (lowest index first), counts distinct bits and flags ordering / zero-beat violations.
module index_decoder3to8 #(
    parameter bit ORDER_CHECK = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] in_idx,
    input  logic       in_zero,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_vec,
    output logic [3:0] out_count,
    output logic       out_err
);

    localparam logic [0:0] ST_COLLECT = 1'b0;
    localparam logic [0:0] ST_HOLD    = 1'b1;

    logic [0:0] r_state;
    logic [7:0] r_acc;
    logic [3:0] r_cnt;
    logic       r_err;
    logic [2:0] r_prev;
    logic       r_seen;       // at least one beat of the current frame accepted
    logic       r_zero_first; // the frame opened with a zero beat

    logic       w_accept;
    logic [7:0] w_onehot;
    logic       w_new_bit;
    logic       w_beat_err;

    assign w_accept  = in_valid && (r_state == ST_COLLECT);
    assign w_onehot  = 8'b0000_0001 << in_idx;
    assign w_new_bit = !in_zero && !r_acc[in_idx];

    always_comb begin
        w_beat_err = 1'b0;
        if (in_zero) begin
            if (r_seen || !in_last) w_beat_err = 1'b1;
        end else if (ORDER_CHECK && r_seen && (in_idx <= r_prev)) begin
            w_beat_err = 1'b1;
        end
        // Anything following a leading zero beat breaks the frame.
        if (r_seen && r_zero_first) w_beat_err = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_COLLECT;
            r_acc        <= 8'h00;
            r_cnt        <= 4'd0;
            r_err        <= 1'b0;
            r_prev       <= 3'd0;
            r_seen       <= 1'b0;
            r_zero_first <= 1'b0;
        end else if (r_state == ST_COLLECT) begin
            if (w_accept) begin
                if (!in_zero) begin
                    r_acc  <= r_acc | w_onehot;
                    r_prev <= in_idx;
                end
                if (w_new_bit) r_cnt <= r_cnt + 4'd1;
                if (w_beat_err) r_err <= 1'b1;
                if (!r_seen) r_zero_first <= in_zero;
                r_seen <= 1'b1;
                if (in_last) r_state <= ST_HOLD;
            end
        end else begin
            if (out_ready) begin
                r_state      <= ST_COLLECT;
                r_acc        <= 8'h00;
                r_cnt        <= 4'd0;
                r_err        <= 1'b0;
                r_seen       <= 1'b0;
                r_zero_first <= 1'b0;
            end
        end
    end

    assign in_ready  = (r_state == ST_COLLECT);
    assign out_valid = (r_state == ST_HOLD);
    assign out_vec   = r_acc;
    assign out_count = r_cnt;
    assign out_err   = r_err;

endmodule

// File: tb/tb_index_decoder3to8.sv
// Directed bench for index_decoder3to8; one instance with ordering checks on, one with them off.
module tb_index_decoder3to8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [2:0] in_idx;
    logic       in_zero;
    logic       in_last;
    logic       out_ready;

    logic       in_ready_a, out_valid_a, out_err_a;
    logic [7:0] out_vec_a;
    logic [3:0] out_count_a;
    logic       in_ready_b, out_valid_b, out_err_b;
    logic [7:0] out_vec_b;
    logic [3:0] out_count_b;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    index_decoder3to8 #(.ORDER_CHECK(1'b1)) dut_chk (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_idx(in_idx), .in_zero(in_zero), .in_last(in_last),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_vec(out_vec_a),
        .out_count(out_count_a), .out_err(out_err_a)
    );

    index_decoder3to8 #(.ORDER_CHECK(1'b0)) dut_nochk (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_idx(in_idx), .in_zero(in_zero), .in_last(in_last),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_vec(out_vec_b),
        .out_count(out_count_b), .out_err(out_err_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and return #1 after the edge that accepted it.
    task automatic send(input logic [2:0] idx, input logic zero, input logic last);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_idx   = idx;
        in_zero  = zero;
        in_last  = last;
        for (int n = 0; n < 50 && !done; n++) begin
            if (in_ready_a) done = 1'b1;
            tick();
        end
        if (!done) begin
            n_cmp++;
            n_fail++;
            $error("FAIL send_timeout observed=%0d expected=%0d", 0, 1);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_idx    = 3'd0;
        in_zero   = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        chk("rst_in_ready", in_ready_a, 1);
        chk("rst_out_valid", out_valid_a, 0);
        chk("rst_out_vec", out_vec_a, 8'h00);
        chk("rst_out_count", out_count_a, 0);
        chk("rst_out_err", out_err_a, 0);
        rst_n = 1'b1;

        // Frame 1,3,6
        send(3'd1, 1'b0, 1'b0);
        send(3'd3, 1'b0, 1'b0);
        send(3'd6, 1'b0, 1'b1);
        chk("f136_valid", out_valid_a, 1);
        chk("f136_in_ready", in_ready_a, 0);
        chk("f136_vec", out_vec_a, 8'b0100_1010);
        chk("f136_count", out_count_a, 3);
        chk("f136_err", out_err_a, 0);
        tick();
        chk("f136_valid_drop", out_valid_a, 0);
        chk("f136_ready_back", in_ready_a, 1);

        // Legal lone zero beat
        send(3'd0, 1'b1, 1'b1);
        chk("zero_valid", out_valid_a, 1);
        chk("zero_vec", out_vec_a, 8'h00);
        chk("zero_count", out_count_a, 0);
        chk("zero_err", out_err_a, 0);

        // Zero beat that is not last, followed by idx 2
        send(3'd0, 1'b1, 1'b0);
        send(3'd2, 1'b0, 1'b1);
        chk("zero2_vec", out_vec_a, 8'h04);
        chk("zero2_count", out_count_a, 1);
        chk("zero2_err", out_err_a, 1);
        chk("zero2_err_nochk", out_err_b, 1);

        // Out of order 5,2
        send(3'd5, 1'b0, 1'b0);
        send(3'd2, 1'b0, 1'b1);
        chk("ooo_vec", out_vec_a, 8'h24);
        chk("ooo_count", out_count_a, 2);
        chk("ooo_err", out_err_a, 1);
        chk("ooo_vec_nochk", out_vec_b, 8'h24);
        chk("ooo_err_nochk", out_err_b, 0);

        // Duplicate 4,4
        send(3'd4, 1'b0, 1'b0);
        send(3'd4, 1'b0, 1'b1);
        chk("dup_vec", out_vec_a, 8'h10);
        chk("dup_count", out_count_a, 1);
        chk("dup_err", out_err_a, 1);
        chk("dup_count_nochk", out_count_b, 1);
        chk("dup_err_nochk", out_err_b, 0);
        tick();

        // All eight bits, consumer stalls while a new beat waits
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(3'(i), 1'b0, i == 7);
        chk("all_valid", out_valid_a, 1);
        chk("all_vec", out_vec_a, 8'hFF);
        chk("all_count", out_count_a, 8);
        chk("all_err", out_err_a, 0);
        in_valid = 1'b1;
        in_idx   = 3'd3;
        in_zero  = 1'b0;
        in_last  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("hold_in_ready", in_ready_a, 0);
            chk("hold_valid", out_valid_a, 1);
            chk("hold_vec", out_vec_a, 8'hFF);
            chk("hold_count", out_count_a, 8);
        end
        out_ready = 1'b1;
        tick();
        chk("release_valid", out_valid_a, 0);
        chk("release_in_ready", in_ready_a, 1);
        tick();
        in_valid = 1'b0;
        chk("held_beat_valid", out_valid_a, 1);
        chk("held_beat_vec", out_vec_a, 8'h08);
        chk("held_beat_count", out_count_a, 1);
        chk("held_beat_err", out_err_a, 0);
        tick();

        // Reset mid-frame discards the partial frame
        send(3'd0, 1'b0, 1'b0);
        send(3'd1, 1'b0, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_vec", out_vec_a, 8'h00);
        chk("midrst_count", out_count_a, 0);
        chk("midrst_in_ready", in_ready_a, 1);
        send(3'd7, 1'b0, 1'b1);
        chk("midrst_f_valid", out_valid_a, 1);
        chk("midrst_f_vec", out_vec_a, 8'h80);
        chk("midrst_f_count", out_count_a, 1);
        chk("midrst_f_err", out_err_a, 0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/index_decoder3to8.md
# index_decoder3to8

Sequential 3-to-8 index decoder that rebuilds an 8-bit request vector from a stream of 3-bit indices, one set bit per beat. It is the receive end of the serialised lowest-index-first priority encoding path. The encoder side reports the least-significant set bit, clears it and repeats. This block decodes each index to one-hot, ORs it into an accumulator, checks ordering, and presents the whole vector once the final beat is seen.

## Interface
- ORDER_CHECK, 1, when 1 flag indices that are not strictly increasing within a frame; when 0 ordering is not checked
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  synchronous, active-low reset
- in_valid  input  1  index beat present
- in_ready  output  1  block can accept a beat this cycle
- in_idx  input  3  bit position (0..7) to set; ignored when in_zero=1
- in_zero  input  1  beat means "no bit set"; legal only as the sole beat of a frame
- in_last  input  1  final beat of frame
- out_valid  output  1  decoded frame available
- out_ready  input  1  consumer takes frame
- out_vec  output  8  reconstructed vector, bit i = a_i
- out_count  output  4  number of distinct bits set in out_vec (0..8)
- out_err  output  1  frame violated ordering or zero-beat rules

## Operation
- States: COLLECT (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
- Beat accepted when in_valid & in_ready. In COLLECT, for each accepted beat:
  - in_zero=0: acc |= (1 << in_idx). cnt increments only if that bit was previously 0. If ORDER_CHECK=1 and this is not the first beat and in_idx <= prev_idx, set err. Then prev_idx := in_idx.
  - in_zero=1: acc and cnt are unchanged. If this is not the first beat of the frame, or in_last=0, set err.
  - If the frame's first beat had in_zero=1 and a further beat arrives, set err.
  - err is sticky within the frame.
- When the accepted beat has in_last=1, go to HOLD. out_vec/out_count/out_err show the final values including that beat.
- HOLD: outputs are stable while out_ready=0. When out_valid & out_ready, clear acc, cnt, err and the first-beat flag, and return to COLLECT.
- A beat presented during HOLD is not accepted, because in_ready=0. The upstream side must hold in_valid and its data.
- cnt width 4. It cannot exceed 8 because duplicates do not count.
- Reset (rst_n=0 at an edge):
  - state goes to COLLECT; acc, cnt, err, prev_idx and the first-beat flag are cleared.
  - Output reset values: in_ready=1, out_valid=0, out_vec=8'h00, out_count=0, out_err=0.
  - Reset asserted mid-frame or during HOLD discards the partial or pending frame.
- in_ready is a function of state only and does not depend combinationally on out_ready.

## Timing
- Throughput is one beat per cycle in COLLECT.
- Last beat accepted at edge N: out_valid=1 from N (visible in cycle N+1).
- Output handshake at edge M: in_ready=1 from M, so the next beat can be accepted at edge M+1. This gives one bubble cycle per frame.
- A one-beat frame therefore takes a minimum of 2 cycles per frame.
- All outputs are registered or decoded from registered state only.

## Test plan
- Reset then stream idx 1,3,6 (last on 6), out_ready=1 → out_vec=8'b0100_1010, out_count=3, out_err=0, out_valid for exactly one cycle, in_ready back 1 cycle later.
- Single beat in_zero=1, in_last=1 → out_vec=8'h00, out_count=0, out_err=0. Then in_zero=1 with in_last=0 followed by idx 2 → out_vec=8'h04, out_err=1.
- Out-of-order stream 5,2 (last) with ORDER_CHECK=1 → out_vec=8'h24, out_err=1. The same stream with ORDER_CHECK=0 gives out_err=0.
- Duplicate stream 4,4 (last) → out_vec=8'h10, out_count=1, out_err=1.
- All eight indices 0..7 with out_ready held 0 for 5 cycles → out_vec=8'hFF, out_count=8, outputs stable, in_ready=0 throughout HOLD, and a beat offered during HOLD is not consumed.
- Beats 0,1 accepted, then rst_n=0 for one cycle, then beat 7 (last) → out_vec=8'h80, out_count=1, out_err=0.
